uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_rx.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- asynchronous serial receiver with runtime frame configuration.
//
// Receives 5..8 data bits (LSB first), an optional parity bit and one stop
// bit. The frame format and bit period are latched when a start edge is
// accepted, so configuration inputs may change freely while a frame is in
// flight. A finished word is held on Rx_Data_o with a valid/ack handshake.
//
// Optional feature:
//   UART_RX_MAJORITY_VOTE_EN  when defined, every bit decision is the 2-of-3
//                             majority of the synchronized line at the
//                             divider target-1, target and target+1; the state
//                             advances after target+1. Undefined (default):
//                             one sample at the target.
//
// Ports:
//   m_clock              in   sole clock, rising edge
//   p_reset              in   synchronous active-high reset
//   RxD_i                in   serial line, asynchronous, idle high
//   Freq_Divide_Param_i  in   [15:0] m_clock cycles per bit (0/1 act as 2)
//   Rx_BitLength_i       in   [1:0]  data bits: 0=5, 1=6, 2=7, 3=8
//   Rx_ParityEN_i        in   parity bit follows the data bits
//   Rx_OddParity_i       in   1 = odd parity, 0 = even parity
//   Rx_Enable_i          in   receiver enable
//   Rx_Ack_i             in   consumer accepts the held word
//   Rx_Data_o            out  [7:0] received word, LSB-aligned, upper bits 0
//   Rx_Valid_o           out  Rx_Data_o holds an unacknowledged word
//   Rx_ParityErr_o       out  parity mismatch on the held word
//   Rx_FrameErr_o        out  stop bit sampled low on the held word
//   Rx_Overrun_o         out  sticky: a completed frame was dropped
//   Rx_Busy_o            out  receiver FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx (
    input  logic        m_clock,
    input  logic        p_reset,
    input  logic        RxD_i,
    input  logic [15:0] Freq_Divide_Param_i,
    input  logic [1:0]  Rx_BitLength_i,
    input  logic        Rx_ParityEN_i,
    input  logic        Rx_OddParity_i,
    input  logic        Rx_Enable_i,
    input  logic        Rx_Ack_i,
    output logic [7:0]  Rx_Data_o,
    output logic        Rx_Valid_o,
    output logic        Rx_ParityErr_o,
    output logic        Rx_FrameErr_o,
    output logic        Rx_Overrun_o,
    output logic        Rx_Busy_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        rxd_p0;
    logic        rxd_p1;
    logic        rxd_p2;

    logic [15:0] div_r;
    logic [15:0] div_cnt;
    logic [15:0] target;
    logic [2:0]  bit_cnt;
    logic [2:0]  last_bit;
    logic [1:0]  len_r;
    logic        par_en_r;
    logic        odd_r;
    logic [7:0]  data_r;
    logic        par_bit_r;

    logic        start_edge;
    logic        sample_stb;
    logic        bit_val;
    logic        deliver;
    logic        par_err_new;

    // A bit period below two cycles cannot place a mid-bit sample.
    function automatic logic [15:0] sat_div(input logic [15:0] d);
        return (d < 16'd2) ? 16'd2 : d;
    endfunction

    // Stage p0/p1: two-flop synchronizer; rxd_p1 is the line as seen by all logic.
    // Stage p2: previous synchronized value, used only for falling-edge detect.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
            rxd_p2 <= 1'b1;
        end else begin
            rxd_p0 <= RxD_i;
            rxd_p1 <= rxd_p0;
            rxd_p2 <= rxd_p1;
        end
    end

    // Edge (not level) detect: a line held low after a framing error never
    // re-arms the receiver until it has been seen high again.
    assign start_edge = rxd_p2 & ~rxd_p1;

    // Start bit is checked half a period in; every later bit a full period on.
    assign target   = (state == S_START) ? {1'b0, div_r[15:1]} : (div_r - 16'd1);
    assign last_bit = {1'b0, len_r} + 3'd4;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic vote_a;
    logic vote_b;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            vote_a <= 1'b1;
            vote_b <= 1'b1;
        end else begin
            if ((state != S_IDLE) && (div_cnt == (target - 16'd1)))
                vote_a <= rxd_p1;
            if ((state != S_IDLE) && (div_cnt == target))
                vote_b <= rxd_p1;
        end
    end

    assign sample_stb = (state != S_IDLE) && (div_cnt == (target + 16'd1));
    assign bit_val    = maj3(vote_a, vote_b, rxd_p1);
`else
    assign sample_stb = (state != S_IDLE) && (div_cnt == target);
    assign bit_val    = rxd_p1;
`endif

    // FSM state register
    always_ff @(posedge m_clock) begin
        if (p_reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        if (!Rx_Enable_i) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start_edge) state_nxt = S_START;
                S_START:  if (sample_stb) state_nxt = bit_val ? S_IDLE : S_DATA;
                S_DATA:   if (sample_stb && (bit_cnt == last_bit))
                              state_nxt = par_en_r ? S_PARITY : S_STOP;
                S_PARITY: if (sample_stb) state_nxt = S_STOP;
                S_STOP:   if (sample_stb) state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        Rx_Busy_o = (state != S_IDLE);
    end

    // Frame datapath: configuration latch, counters and bit assembly.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            div_r     <= 16'd2;
            len_r     <= 2'd0;
            par_en_r  <= 1'b0;
            odd_r     <= 1'b0;
            div_cnt   <= 16'd0;
            bit_cnt   <= 3'd0;
            data_r    <= 8'd0;
            par_bit_r <= 1'b0;
        end else begin
            if ((state == S_IDLE) && (state_nxt == S_START)) begin
                div_r     <= sat_div(Freq_Divide_Param_i);
                len_r     <= Rx_BitLength_i;
                par_en_r  <= Rx_ParityEN_i;
                odd_r     <= Rx_OddParity_i;
                bit_cnt   <= 3'd0;
                data_r    <= 8'd0;
                par_bit_r <= 1'b0;
            end

            if ((state == S_IDLE) || (state_nxt != state) || sample_stb)
                div_cnt <= 16'd0;
            else
                div_cnt <= div_cnt + 16'd1;

            if ((state == S_DATA) && sample_stb) begin
                data_r[bit_cnt] <= bit_val;
                bit_cnt         <= bit_cnt + 3'd1;
            end

            if ((state == S_PARITY) && sample_stb)
                par_bit_r <= bit_val;
        end
    end

    assign deliver     = (state == S_STOP) && sample_stb && Rx_Enable_i;
    // Unused upper data bits are zero, so a full-width XOR is exact.
    assign par_err_new = par_en_r & (((^data_r) ^ par_bit_r) != odd_r);

    // Output word and handshake. A delivery meeting an unacknowledged word is
    // dropped and flagged; an ack in the delivery cycle frees the slot.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            Rx_Data_o      <= 8'd0;
            Rx_Valid_o     <= 1'b0;
            Rx_ParityErr_o <= 1'b0;
            Rx_FrameErr_o  <= 1'b0;
            Rx_Overrun_o   <= 1'b0;
        end else if (deliver) begin
            if (Rx_Valid_o && !Rx_Ack_i) begin
                Rx_Overrun_o <= 1'b1;
            end else begin
                Rx_Data_o      <= data_r;
                Rx_ParityErr_o <= par_err_new;
                Rx_FrameErr_o  <= ~bit_val;
                Rx_Valid_o     <= 1'b1;
                if (Rx_Ack_i)
                    Rx_Overrun_o <= 1'b0;
            end
        end else if (Rx_Valid_o && Rx_Ack_i) begin
            Rx_Valid_o   <= 1'b0;
            Rx_Overrun_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx (default build).
//
// Frames are described as bit lists; the bench computes from them the word,
// parity and framing flags each frame must deliver, the clock edge at which
// delivery must happen and the interval during which the receiver is busy.
// A handshake model applies ack/overrun rules; a compare process checks every
// output on every cycle, and directed scenarios add literal expectations.
//
// Timing used by the model (edges counted from the edge E0 after which the
// line falls): two synchronizer edges plus one edge-detect cycle put the FSM
// in START after E0+3; the start check lands div/2 cycles later (left at
// E0+4+div/2), and each further bit takes div cycles, so a frame of nb
// data+parity bits delivers at edge E0+4+div/2+(nb+1)*div.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

    logic        m_clock = 1'b0;
    logic        p_reset;
    logic        RxD_i;
    logic [15:0] Freq_Divide_Param_i;
    logic [1:0]  Rx_BitLength_i;
    logic        Rx_ParityEN_i;
    logic        Rx_OddParity_i;
    logic        Rx_Enable_i;
    logic        Rx_Ack_i;
    logic [7:0]  Rx_Data_o;
    logic        Rx_Valid_o;
    logic        Rx_ParityErr_o;
    logic        Rx_FrameErr_o;
    logic        Rx_Overrun_o;
    logic        Rx_Busy_o;

    always #5 m_clock = ~m_clock;

    uart_rx dut (
        .m_clock             (m_clock),
        .p_reset             (p_reset),
        .RxD_i               (RxD_i),
        .Freq_Divide_Param_i (Freq_Divide_Param_i),
        .Rx_BitLength_i      (Rx_BitLength_i),
        .Rx_ParityEN_i       (Rx_ParityEN_i),
        .Rx_OddParity_i      (Rx_OddParity_i),
        .Rx_Enable_i         (Rx_Enable_i),
        .Rx_Ack_i            (Rx_Ack_i),
        .Rx_Data_o           (Rx_Data_o),
        .Rx_Valid_o          (Rx_Valid_o),
        .Rx_ParityErr_o      (Rx_ParityErr_o),
        .Rx_FrameErr_o       (Rx_FrameErr_o),
        .Rx_Overrun_o        (Rx_Overrun_o),
        .Rx_Busy_o           (Rx_Busy_o)
    );

    typedef struct {
        int         edge_n;
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } dlv_t;

    int         checks   = 0;
    int         failures = 0;
    int         ecnt     = 0;
    int         bs       = 0;
    int         be       = 0;
    int         last_e0  = 0;
    int         rise_edge = -1;
    int         ack_pct  = 0;
    int         ack_edge = -1;
    bit         ack_on_dlv = 1'b0;
    logic       ack_force = 1'b0;
    logic       ack_rnd   = 1'b0;
    logic       prev_valid = 1'b0;

    logic [7:0] exp_data  = 8'd0;
    logic       exp_valid = 1'b0;
    logic       exp_pe    = 1'b0;
    logic       exp_fe    = 1'b0;
    logic       exp_ovr   = 1'b0;
    logic       exp_busy;
    dlv_t       dq[$];
    dlv_t       cur;

    assign Rx_Ack_i = ack_force | ack_rnd;

    always @(negedge m_clock) begin
        ack_rnd = (int'($urandom_range(0, 99)) < ack_pct) || ((ecnt + 1) == ack_edge);
    end

    // Handshake model, evaluated with the inputs seen at each rising edge.
    always @(posedge m_clock) begin
        ecnt = ecnt + 1;
        if (p_reset) begin
            exp_data  = 8'd0;
            exp_valid = 1'b0;
            exp_pe    = 1'b0;
            exp_fe    = 1'b0;
            exp_ovr   = 1'b0;
            dq.delete();
        end else if ((dq.size() > 0) && (dq[0].edge_n == ecnt)) begin
            cur = dq.pop_front();
            if (exp_valid && !Rx_Ack_i) begin
                exp_ovr = 1'b1;
            end else begin
                if (exp_valid) exp_ovr = 1'b0;
                exp_data  = cur.data;
                exp_pe    = cur.pe;
                exp_fe    = cur.fe;
                exp_valid = 1'b1;
            end
        end else if (exp_valid && Rx_Ack_i) begin
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
        end
    end

    always @(negedge m_clock) begin
        if (ecnt >= 1) begin
            exp_busy = (ecnt >= bs) && (ecnt < be);
            checks = checks + 1;
            if ((Rx_Data_o !== exp_data) || (Rx_Valid_o !== exp_valid) ||
                (Rx_ParityErr_o !== exp_pe) || (Rx_FrameErr_o !== exp_fe) ||
                (Rx_Overrun_o !== exp_ovr) || (Rx_Busy_o !== exp_busy)) begin
                failures = failures + 1;
                $display("FAIL outputs edge=%0d: got data=%h v=%b pe=%b fe=%b ovr=%b busy=%b required data=%h v=%b pe=%b fe=%b ovr=%b busy=%b",
                         ecnt, Rx_Data_o, Rx_Valid_o, Rx_ParityErr_o, Rx_FrameErr_o, Rx_Overrun_o, Rx_Busy_o,
                         exp_data, exp_valid, exp_pe, exp_fe, exp_ovr, exp_busy);
            end
            if (Rx_Valid_o === 1'b1 && prev_valid !== 1'b1) rise_edge = ecnt;
            prev_valid = Rx_Valid_o;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks = checks + 1;
        if (act !== expv) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h required %0h", nm, act, expv);
        end
    endtask

    task automatic do_ack();
        ack_force = 1'b1;
        @(negedge m_clock);
        ack_force = 1'b0;
    endtask

    // abort: 0 none, 1 drop Rx_Enable_i, 2 pulse p_reset (both during data bit 3)
    task automatic send_frame(input int div, input int blen, input bit pen, input bit odd,
                              input logic [7:0] data, input bit pbit, input bit stopb,
                              input int hold_low, input int abort, input bit scramble);
        int         n;
        int         nb;
        int         h;
        int         e0;
        int         d;
        bit         aborted;
        logic [7:0] m;
        logic [7:0] dm;
        logic       bits [0:11];
        dlv_t       f;
        n  = blen + 5;
        nb = n + (pen ? 1 : 0);
        h  = div / 2;
        m  = 8'hFF >> (8 - n);
        dm = data & m;
        Freq_Divide_Param_i = 16'(div);
        Rx_BitLength_i      = 2'(blen);
        Rx_ParityEN_i       = pen;
        Rx_OddParity_i      = odd;
        for (int i = 0; i < 12; i++) bits[i] = 1'b1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) if (i < n) bits[1 + i] = data[i];
        if (pen) bits[1 + n] = pbit;
        bits[nb + 1] = stopb;
        e0 = ecnt;
        last_e0 = e0;
        d  = e0 + 4 + h + (nb + 1) * div;
        bs = e0 + 3;
        be = d;
        ack_edge = ack_on_dlv ? d : -1;
        if (abort == 0) begin
            f.edge_n = d;
            f.data   = dm;
            f.pe     = pen && (((^dm) ^ pbit) != odd);
            f.fe     = !stopb;
            dq.push_back(f);
        end
        aborted = 1'b0;
        for (int k = 0; (k <= nb + 1) && !aborted; k++) begin
            RxD_i = bits[k];
            for (int c = 0; (c < div) && !aborted; c++) begin
                if ((abort != 0) && (k == 4) && (c == h)) begin
                    RxD_i = 1'b1;
                    be = ecnt + 1;
                    if (abort == 1) Rx_Enable_i = 1'b0;
                    else            p_reset     = 1'b1;
                    @(negedge m_clock);
                    p_reset = 1'b0;
                    repeat (6) @(negedge m_clock);
                    Rx_Enable_i = 1'b1;
                    repeat (4) @(negedge m_clock);
                    aborted = 1'b1;
                end else begin
                    @(negedge m_clock);
                    if (scramble && (k == 0) && (c == 4)) begin
                        Freq_Divide_Param_i = 16'($urandom_range(0, 65535));
                        Rx_BitLength_i      = 2'($urandom_range(0, 3));
                        Rx_ParityEN_i       = 1'($urandom_range(0, 1));
                        Rx_OddParity_i      = 1'($urandom_range(0, 1));
                    end
                end
            end
        end
        if (!aborted) begin
            if (!stopb) begin
                RxD_i = 1'b0;
                repeat (hold_low * div) @(negedge m_clock);
            end
            RxD_i = 1'b1;
            repeat (4) @(negedge m_clock);
            while (ecnt < d + 1) @(negedge m_clock);
        end
        ack_edge = -1;
    endtask

    // Line low for low_cyc cycles, shorter than the half-bit start check.
    task automatic false_start(input int div, input int low_cyc);
        int e0;
        Freq_Divide_Param_i = 16'(div);
        e0 = ecnt;
        bs = e0 + 3;
        be = e0 + 4 + div / 2;
        RxD_i = 1'b0;
        repeat (low_cyc) @(negedge m_clock);
        RxD_i = 1'b1;
        while (ecnt < be + 4) @(negedge m_clock);
    endtask

    initial begin
        int div;
        int sel;
        int ab;
        bit sb;
        p_reset             = 1'b1;
        RxD_i               = 1'b1;
        Freq_Divide_Param_i = 16'd32;
        Rx_BitLength_i      = 2'd3;
        Rx_ParityEN_i       = 1'b0;
        Rx_OddParity_i      = 1'b0;
        Rx_Enable_i         = 1'b1;
        repeat (3) @(negedge m_clock);
        chk("reset_data",  32'(Rx_Data_o), 32'h0);
        chk("reset_valid", 32'(Rx_Valid_o), 32'h0);
        chk("reset_busy",  32'(Rx_Busy_o), 32'h0);
        chk("reset_flags", 32'({Rx_ParityErr_o, Rx_FrameErr_o, Rx_Overrun_o}), 32'h0);
        p_reset = 1'b0;
        repeat (4) @(negedge m_clock);

        // 8N1 0x38 at div 32; delivery 4+16+9*32 = 308 edges after the fall
        send_frame(32, 3, 0, 0, 8'h38, 0, 1, 0, 0, 0);
        chk("n81_data",    32'(Rx_Data_o), 32'h38);
        chk("n81_valid",   32'(Rx_Valid_o), 32'h1);
        chk("n81_flags",   32'({Rx_ParityErr_o, Rx_FrameErr_o, Rx_Overrun_o}), 32'h0);
        chk("n81_latency", 32'(rise_edge - last_e0), 32'd308);
        do_ack();
        chk("n81_ack_valid", 32'(Rx_Valid_o), 32'h0);

        // 7 bits odd parity, 0x55 has four ones
        send_frame(32, 2, 1, 1, 8'h55, 0, 1, 0, 0, 0);
        chk("par0_data", 32'(Rx_Data_o), 32'h55);
        chk("par0_perr", 32'(Rx_ParityErr_o), 32'h1);
        do_ack();
        send_frame(32, 2, 1, 1, 8'h55, 1, 1, 0, 0, 0);
        chk("par1_data", 32'(Rx_Data_o), 32'h55);
        chk("par1_perr", 32'(Rx_ParityErr_o), 32'h0);
        do_ack();

        false_start(32, 10);
        chk("false_valid", 32'(Rx_Valid_o), 32'h0);
        chk("false_busy",  32'(Rx_Busy_o), 32'h0);

        // stop bit low, line held low 20 more bit times
        send_frame(32, 3, 0, 0, 8'hA5, 0, 0, 20, 0, 0);
        chk("ferr_data",  32'(Rx_Data_o), 32'hA5);
        chk("ferr_flag",  32'(Rx_FrameErr_o), 32'h1);
        chk("ferr_ovr",   32'(Rx_Overrun_o), 32'h0);
        chk("ferr_busy",  32'(Rx_Busy_o), 32'h0);
        do_ack();

        send_frame(32, 3, 0, 0, 8'h11, 0, 1, 0, 0, 0);
        send_frame(32, 3, 0, 0, 8'h22, 0, 1, 0, 0, 0);
        chk("ovr_data",  32'(Rx_Data_o), 32'h11);
        chk("ovr_flag",  32'(Rx_Overrun_o), 32'h1);
        do_ack();
        chk("ovr_ack_valid", 32'(Rx_Valid_o), 32'h0);
        chk("ovr_ack_flag",  32'(Rx_Overrun_o), 32'h0);

        send_frame(32, 3, 0, 0, 8'hF0, 0, 1, 0, 2, 0);
        chk("rst_abort_valid", 32'(Rx_Valid_o), 32'h0);
        chk("rst_abort_busy",  32'(Rx_Busy_o), 32'h0);
        send_frame(32, 3, 0, 0, 8'h0F, 0, 1, 0, 0, 0);
        chk("rst_next_data",  32'(Rx_Data_o), 32'h0F);
        chk("rst_next_flags", 32'({Rx_ParityErr_o, Rx_FrameErr_o, Rx_Overrun_o}), 32'h0);

        // held word acknowledged in the very cycle the next frame delivers
        ack_on_dlv = 1'b1;
        send_frame(16, 3, 0, 0, 8'h3C, 0, 1, 0, 0, 0);
        ack_on_dlv = 1'b0;
        chk("same_cycle_data",  32'(Rx_Data_o), 32'h3C);
        chk("same_cycle_valid", 32'(Rx_Valid_o), 32'h1);
        chk("same_cycle_ovr",   32'(Rx_Overrun_o), 32'h0);
        do_ack();

        for (int it = 0; it < 40; it++) begin
            sel = int'($urandom_range(0, 9));
            case ($urandom_range(0, 2))
                0:       ack_pct = 0;
                1:       ack_pct = 3;
                default: ack_pct = 50;
            endcase
            div = int'($urandom_range(4, 24));
            if (sel == 0) begin
                false_start(div, int'($urandom_range(1, div / 2 + 1)));
            end else begin
                ab = (sel == 1) ? 1 : ((sel == 2) ? 2 : 0);
                sb = (sel != 3);
                send_frame(div, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                           1'($urandom_range(0, 1)), sb, sb ? 0 : int'($urandom_range(0, 3)),
                           ab, 1'($urandom_range(0, 1)));
            end
            repeat ($urandom_range(0, 8)) @(negedge m_clock);
        end

        ack_pct = 0;
        repeat (20) @(negedge m_clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
